gpr_restore: RTL and testbench
==============================

# gpr_restore

Host-to-core counterpart of the GPR snapshot path: accepts a full general-purpose register image from the simulation environment (checkpoint restore, difftest resync) and loads it into the core register file through its write port. After writing, it reads every register back and flags the first mismatch. While active it holds the core stalled. It sits between the testbench/DPI glue and the register file's spare write/read ports.

## Interface

Parameters:
- NUM_REGS, 32, architectural GPR count; legal values are only 16 (RV32E) or 32 (RV32I).
- XLEN, 32, register width.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- load_valid  in  1  image offered.
- load_ready  out  1  block idle and able to accept an image.
- load_image  in  NUM_REGS*XLEN  register i at bits [XLEN*(i+1)-1 : XLEN*i]; slot 0 is ignored.
- core_stall  out  1  core must not retire or write GPRs.
- rf_we  out  1  register file write enable.
- rf_waddr  out  5  write address.
- rf_wdata  out  XLEN  write data.
- rf_raddr  out  5  read address; rf_rdata is valid the cycle after.
- rf_rdata  in  XLEN  registered read data, 1-cycle latency.
- done  out  1  one-cycle pulse at end of sequence.
- error  out  1  readback mismatch seen; sticky until next accept.
- err_idx  out  5  lowest mismatching register index; 0 when error=0.

Clock is clk. Reset is resetn: synchronous, active-low.

## Operation

- States: IDLE, WRITE, VERIFY, DONE.
- IDLE:
  - load_ready=1 and core_stall=0.
  - On load_valid&&load_ready, capture load_image into the internal buffer, clear error and err_idx, set idx=1, and go to WRITE.
- WRITE:
  - Drive rf_we=1, rf_waddr=idx, rf_wdata=buf[idx], then idx++.
  - After idx=NUM_REGS-1, go to VERIFY with idx=1.
  - x0 is never written.
- VERIFY:
  - Issue rf_raddr=idx for idx 1..NUM_REGS-1 on consecutive cycles.
  - A delayed-address pipeline register compares rf_rdata against buf[delayed idx] one cycle after each issue.
  - The state stays in VERIFY for one extra cycle after the last issue so the final compare completes. rf_raddr is 0 in that cycle.
  - On the first mismatch: error=1 and err_idx=delayed idx. Later mismatches do not change err_idx.
- DONE: done=1 for one cycle, then go to IDLE.
- core_stall = (state != IDLE).
- load_valid while not IDLE is ignored and has no side effects. load_image is sampled only at accept.
- Outputs outside their active state: rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0, done=0.

## Timing

- Reset (resetn=0 at a rising edge) sets:
  - state IDLE, idx=1;
  - load_ready=1, core_stall=0, rf_we=0, rf_waddr=0, rf_wdata=0, rf_raddr=0, done=0, error=0, err_idx=0.
  - The buffer is not cleared.
- Reset mid-sequence aborts at that edge: rf_we=0 and core_stall=0 from the next cycle. The register file keeps whatever writes were already made.
- Let accept be cycle 0 and N=NUM_REGS:
  - Writes occur in cycles 1..N-1.
  - Read issues occur in cycles N..2N-2.
  - Compares occur in cycles N+1..2N-1.
  - done is high in cycle 2N (64 for N=32, 32 for N=16).
  - load_ready returns at cycle 2N+1.
- Back-to-back operation: a new accept is possible at cycle 2N+1, so the minimum period is 2N+1 cycles.
- error and err_idx update at the edge ending a compare cycle. They are stable when done is high and hold until the next accept.
- Widths: idx is 5 bits, with terminal value N-1. For N=16, no address above 15 is ever driven.

## Test plan

- N=32, image[i]=i*32'h01010101, ideal RF model. Expect:
  - 31 writes x1..x31 in cycles 1..31 with matching data;
  - reads x1..x31 in cycles 32..62;
  - done in cycle 64 with error=0, err_idx=0;
  - core_stall high in cycles 1..64.
- image[0]=32'hDEADBEEF with the rest as above. Expect no write with rf_waddr=0 and error=0.
- RF model corrupts readback of x7 and x20 (XOR 1). Expect error=1, err_idx=7 at done; both hold through 5 idle cycles.
- N=16, random image. Expect done at cycle 32, all rf_waddr and rf_raddr in 1..15, error=0.
- resetn=0 at cycle 10 of a sequence:
  - Cycle 11: rf_we=0, core_stall=0, load_ready=1.
  - A new accept then completes normally at cycle 64 relative to it.
- load_valid held high through a faulty sequence, with a new image offered at cycle 65. Expect:
  - no accept before cycle 65;
  - error cleared at that accept;
  - a clean run ends with error=0.

Source files
------------

// File: rtl/gpr_restore.sv
// Loads a host-supplied GPR image into the core register file, reads it back to verify it,
// and flags the lowest register index whose readback mismatched. Holds the core stalled while busy.
//
//   state  | meaning
//   IDLE   | ready for an image, core runs
//   WRITE  | writing x1..x(N-1) from the captured image
//   VERIFY | issuing reads x1..x(N-1), plus one tail cycle for the last compare
//   DONE   | one-cycle completion pulse
module gpr_restore #(
    parameter int NUM_REGS = 32,  // 16 (RV32E) or 32 (RV32I)
    parameter int XLEN     = 32
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     load_valid,
    output logic                     load_ready,
    input  logic [NUM_REGS*XLEN-1:0] load_image,
    output logic                     core_stall,
    output logic                     rf_we,
    output logic [4:0]               rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    output logic [4:0]               rf_raddr,
    input  logic [XLEN-1:0]          rf_rdata,
    output logic                     done,
    output logic                     error,
    output logic [4:0]               err_idx
);

    localparam int         IW   = $clog2(NUM_REGS);
    localparam logic [4:0] LAST = 5'(NUM_REGS - 1);

    typedef enum logic [1:0] {IDLE, WRITE, VERIFY, DONE} state_t;

    state_t          state_q, state_d;
    logic [4:0]      idx_q, idx_d;
    logic            tail_q, tail_d;
    logic [XLEN-1:0] img_q [NUM_REGS];
    logic            cmp_vld_q;
    logic [4:0]      cmp_idx_q;
    logic            error_q;
    logic [4:0]      err_idx_q;
    logic            accept;

    assign accept = (state_q == IDLE) && load_valid;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
            idx_q   <= 5'd1;
            tail_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tail_q  <= tail_d;
        end
    end

    // Image buffer is deliberately not reset; it is only meaningful after an accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                img_q[i] <= load_image[i*XLEN +: XLEN];
            end
        end
    end

    // Read data arrives one cycle after the issue, so the issued index is delayed to match it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            cmp_vld_q <= 1'b0;
            cmp_idx_q <= 5'd0;
            error_q   <= 1'b0;
            err_idx_q <= 5'd0;
        end else begin
            cmp_vld_q <= (state_q == VERIFY) && !tail_q;
            cmp_idx_q <= idx_q;
            if (accept) begin
                error_q   <= 1'b0;
                err_idx_q <= 5'd0;
            end else if (cmp_vld_q && !error_q &&
                         (rf_rdata != img_q[cmp_idx_q[IW-1:0]])) begin
                error_q   <= 1'b1;
                err_idx_q <= cmp_idx_q;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        tail_d     = tail_q;
        load_ready = 1'b0;
        rf_we      = 1'b0;
        rf_waddr   = 5'd0;
        rf_wdata   = '0;
        rf_raddr   = 5'd0;
        done       = 1'b0;
        case (state_q)
            IDLE: begin
                load_ready = 1'b1;
                if (load_valid) begin
                    state_d = WRITE;
                    idx_d   = 5'd1;
                    tail_d  = 1'b0;
                end
            end
            WRITE: begin
                rf_we    = 1'b1;
                rf_waddr = idx_q;
                rf_wdata = img_q[idx_q[IW-1:0]];
                if (idx_q == LAST) begin
                    state_d = VERIFY;
                    idx_d   = 5'd1;
                end else begin
                    idx_d = idx_q + 5'd1;
                end
            end
            VERIFY: begin
                if (tail_q) begin
                    state_d = DONE;
                    tail_d  = 1'b0;
                    idx_d   = 5'd1;
                end else begin
                    rf_raddr = idx_q;
                    if (idx_q == LAST) begin
                        tail_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 5'd1;
                    end
                end
            end
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_stall = (state_q != IDLE);
    assign error      = error_q;
    assign err_idx    = err_idx_q;

endmodule

// File: tb/tb_gpr_restore.sv
// Bench for gpr_restore: RV32I and RV32E instances driven with random images against an
// ideal register file that can corrupt chosen readbacks.
module tb_gpr_restore;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic          lv32, lr32, st32, we32, dn32, er32;
    logic [1023:0] img32;
    logic [4:0]    wa32, ra32, ei32;
    logic [31:0]   wd32, rd32;

    logic          lv16, lr16, st16, we16, dn16, er16;
    logic [511:0]  img16;
    logic [4:0]    wa16, ra16, ei16;
    logic [31:0]   wd16, rd16;

    int checks = 0;
    int errors = 0;

    logic [31:0] rf32 [32];
    logic [31:0] rf16 [16];
    logic [31:0] bad32 = 32'd0;
    logic [15:0] bad16 = 16'd0;

    gpr_restore #(.NUM_REGS(32), .XLEN(32)) u_dut32 (
        .clk(clk), .resetn(resetn), .load_valid(lv32), .load_ready(lr32),
        .load_image(img32), .core_stall(st32), .rf_we(we32), .rf_waddr(wa32),
        .rf_wdata(wd32), .rf_raddr(ra32), .rf_rdata(rd32), .done(dn32),
        .error(er32), .err_idx(ei32)
    );

    gpr_restore #(.NUM_REGS(16), .XLEN(32)) u_dut16 (
        .clk(clk), .resetn(resetn), .load_valid(lv16), .load_ready(lr16),
        .load_image(img16), .core_stall(st16), .rf_we(we16), .rf_waddr(wa16),
        .rf_wdata(wd16), .rf_raddr(ra16), .rf_rdata(rd16), .done(dn16),
        .error(er16), .err_idx(ei16)
    );

    // Ideal register files with registered read; a set bad bit flips bit 0 of that register's readback.
    always @(posedge clk) begin
        if (we32) rf32[wa32] <= wd32;
        rd32 <= rf32[ra32] ^ {31'd0, bad32[ra32]};
        if (we16) rf16[wa16[3:0]] <= wd16;
        rd16 <= rf16[ra16[3:0]] ^ {31'd0, bad16[ra16[3:0]]};
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "bench stalled");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int first_bad(int n, logic [31:0] bad);
        for (int i = 1; i < n; i++) begin
            if (bad[i]) return i;
        end
        return 0;
    endfunction

    // Expected {stall, we, waddr, wdata, raddr, done, ready, error, err_idx} at cycle c after accept.
    function automatic logic [51:0] exp_vec(int n, int c, logic [1023:0] img, int first);
        logic        we, er;
        logic [4:0]  wa, ra, ei;
        logic [31:0] wd;
        we = (c >= 1) && (c <= n - 1);
        wa = 5'd0;
        wd = 32'd0;
        if (we) begin
            wa = 5'(c);
            wd = img[c*32 +: 32];
        end
        ra = ((c >= n) && (c <= 2*n - 2)) ? 5'(c - n + 1) : 5'd0;
        er = (first != 0) && (c >= n + first + 1);
        ei = er ? 5'(first) : 5'd0;
        return {(c >= 1) && (c <= 2*n), we, wa, wd, ra, c == 2*n, c == 2*n + 1, er, ei};
    endfunction

    function automatic logic [1023:0] rand_img32();
        logic [1023:0] v;
        for (int i = 0; i < 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic run32(input logic [1023:0] img, input logic [31:0] bad,
                         input bit hold, input logic [1023:0] next_img);
        int          first;
        bit          ok;
        logic [51:0] act, exp;
        first = first_bad(32, bad);
        bad32 = bad;
        lv32  = 1'b1;
        img32 = img;
        checks++;
        if (lr32 !== 1'b1) begin
            errors++;
            $display("FAIL run32_accept_ready got %b want 1", lr32);
        end
        for (int c = 1; c <= 65; c++) begin
            tick();
            if (hold) img32 = (c == 65) ? next_img : {32{$urandom}};
            else      lv32  = 1'b0;
            act = {st32, we32, wa32, wd32, ra32, dn32, lr32, er32, ei32};
            exp = exp_vec(32, c, img, first);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL run32_cycle%0d got %h want %h", c, act, exp);
            end
        end
        ok = 1'b1;
        for (int i = 1; i < 32; i++) if (rf32[i] !== img[i*32 +: 32]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run32_rf_contents got mismatch want image x1..x31");
        end
    endtask

    task automatic run16(input logic [511:0] img, input logic [15:0] bad);
        int          first;
        bit          ok;
        logic [51:0] act, exp;
        first = first_bad(16, {16'd0, bad});
        bad16 = bad;
        lv16  = 1'b1;
        img16 = img;
        checks++;
        if (lr16 !== 1'b1) begin
            errors++;
            $display("FAIL run16_accept_ready got %b want 1", lr16);
        end
        for (int c = 1; c <= 33; c++) begin
            tick();
            lv16 = 1'b0;
            act  = {st16, we16, wa16, wd16, ra16, dn16, lr16, er16, ei16};
            exp  = exp_vec(16, c, {512'd0, img}, first);
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL run16_cycle%0d got %h want %h", c, act, exp);
            end
        end
        ok = 1'b1;
        for (int i = 1; i < 16; i++) if (rf16[i] !== img[i*32 +: 32]) ok = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL run16_rf_contents got mismatch want image x1..x15");
        end
    endtask

    task automatic test_reset();
        logic [51:0] idle_v;
        idle_v = {1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 5'd0};
        resetn = 1'b0;
        lv32 = 1'b0; img32 = '0;
        lv16 = 1'b0; img16 = '0;
        repeat (3) tick();
        checks++;
        if ({st32, we32, wa32, wd32, ra32, dn32, lr32, er32, ei32} !== idle_v) begin
            errors++;
            $display("FAIL reset32 got %h want %h",
                     {st32, we32, wa32, wd32, ra32, dn32, lr32, er32, ei32}, idle_v);
        end
        checks++;
        if ({st16, we16, wa16, wd16, ra16, dn16, lr16, er16, ei16} !== idle_v) begin
            errors++;
            $display("FAIL reset16 got %h want %h",
                     {st16, we16, wa16, wd16, ra16, dn16, lr16, er16, ei16}, idle_v);
        end
        resetn = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [1023:0] img;
        for (int i = 0; i < 32; i++) img[i*32 +: 32] = 32'(i) * 32'h01010101;
        run32(img, 32'd0, 1'b0, '0);
        img[31:0] = 32'hDEADBEEF;
        run32(img, 32'd0, 1'b0, '0);
    endtask

    task automatic test_corrupt();
        logic [31:0] bad;
        bad = 32'd0;
        bad[7]  = 1'b1;
        bad[20] = 1'b1;
        run32(rand_img32(), bad, 1'b0, '0);
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if ({er32, ei32, lr32, st32} !== {1'b1, 5'd7, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL corrupt_hold%0d got err=%b idx=%0d ready=%b stall=%b want err=1 idx=7 ready=1 stall=0",
                         k, er32, ei32, lr32, st32);
            end
        end
    endtask

    task automatic test_rv32e();
        logic [511:0] img;
        logic [15:0]  bad;
        for (int i = 0; i < 16; i++) img[i*32 +: 32] = $urandom;
        run16(img, 16'd0);
        for (int i = 0; i < 16; i++) img[i*32 +: 32] = $urandom;
        bad = 16'($urandom) & 16'hFFFE;
        run16(img, bad);
    endtask

    task automatic test_reset_mid();
        lv32  = 1'b1;
        img32 = rand_img32();
        bad32 = 32'd0;
        tick();
        lv32 = 1'b0;
        repeat (9) tick();
        resetn = 1'b0;
        tick();
        checks++;
        if ({we32, st32, lr32} !== 3'b001) begin
            errors++;
            $display("FAIL reset_mid got we=%b stall=%b ready=%b want we=0 stall=0 ready=1",
                     we32, st32, lr32);
        end
        resetn = 1'b1;
        run32(rand_img32(), 32'd0, 1'b0, '0);
    endtask

    task automatic test_back_to_back();
        logic [1023:0] img_b;
        logic [31:0]   bad;
        bad = 32'd0;
        bad[7]  = 1'b1;
        bad[20] = 1'b1;
        img_b = rand_img32();
        run32(rand_img32(), bad, 1'b1, img_b);
        run32(img_b, 32'd0, 1'b0, '0);
    endtask

    task automatic test_random();
        logic [31:0] bad;
        for (int k = 0; k < 6; k++) begin
            bad = (k % 2 == 0) ? 32'd0 : ($urandom & 32'hFFFF_FFFE);
            if (k == 5) bad = 32'h8000_0000;
            run32(rand_img32(), bad, 1'b0, '0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_corrupt();
        test_rv32e();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
